// File: rtl/trace_column_renderer_if.sv
// Column-store write bus from the tracer into the column renderer.
interface trace_column_renderer_if;
  logic       store;
  logic [9:0] column;
  logic       side;
  logic [7:0] height;

  modport master (output store, column, side, height);
  modport slave  (input  store, column, side, height);
endinterface

// File: rtl/trace_column_renderer.sv
// Double-buffered column store for traced wall results, rendered at pixel
// rate into 6-bit colour through a two-stage pipeline.
module trace_column_renderer #(
  parameter int         COLUMNS    = 640,
  parameter int         HORIZON    = 240,
  parameter int         MAX_HEIGHT = 240,
  parameter logic [5:0] SKY        = 6'h0B,
  parameter logic [5:0] FLOOR      = 6'h15,
  parameter logic [5:0] WALL0      = 6'h30,
  parameter logic [5:0] WALL1      = 6'h20
) (
  input  logic                    clk,
  input  logic                    reset,
  trace_column_renderer_if.slave  colBus,
  input  logic                    frame_end,
  input  logic [9:0]              hpos,
  input  logic [9:0]              vpos,
  input  logic                    visible,
  output logic [5:0]              rgb,
  output logic                    front_bank,
  output logic                    front_valid
);

  localparam logic [7:0]  MaxHeight8 = 8'(MAX_HEIGHT);
  localparam logic [10:0] Horizon11  = 11'(HORIZON);
  localparam logic [9:0]  Columns10  = 10'(COLUMNS);

  logic [8:0] bank0 [COLUMNS];
  logic [8:0] bank1 [COLUMNS];

  logic       writeOk;
  logic [7:0] clampedHeight;
  logic       backDirty;

  assign writeOk       = colBus.store && (colBus.column < Columns10);
  assign clampedHeight = (colBus.height > MaxHeight8) ? MaxHeight8 : colBus.height;

  // Bank contents survive reset; the write bank is always the one not on screen.
  always_ff @(posedge clk) begin
    if (writeOk) begin
      if (front_bank) bank0[colBus.column] <= {colBus.side, clampedHeight};
      else            bank1[colBus.column] <= {colBus.side, clampedHeight};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      front_bank  <= 1'b0;
      front_valid <= 1'b0;
      backDirty   <= 1'b0;
    end else if (frame_end) begin
      front_bank  <= ~front_bank;
      front_valid <= backDirty | writeOk;
      backDirty   <= 1'b0;
    end else if (writeOk) begin
      backDirty   <= 1'b1;
    end
  end

  logic [8:0] readWord;

  always_comb begin
    readWord = '0;
    if (front_valid && (hpos < Columns10))
      readWord = front_bank ? bank1[hpos] : bank0[hpos];
  end

  logic       visibleQ;
  logic [9:0] vposQ;
  logic       sideQ;
  logic [7:0] heightQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      visibleQ <= 1'b0;
      vposQ    <= '0;
      sideQ    <= 1'b0;
      heightQ  <= '0;
    end else begin
      visibleQ <= visible;
      vposQ    <= vpos;
      {sideQ, heightQ} <= readWord;
    end
  end

  // 11-bit row arithmetic keeps HORIZON - h from wrapping at full height.
  logic [10:0] heightExt;
  logic [10:0] vposExt;
  logic [10:0] wallTop;
  logic [10:0] wallEnd;
  logic        inWall;

  assign heightExt = {3'b000, heightQ};
  assign vposExt   = {1'b0, vposQ};
  assign wallTop   = Horizon11 - heightExt;
  assign wallEnd   = Horizon11 + heightExt;
  assign inWall    = (heightQ != 8'd0) && (vposExt >= wallTop) && (vposExt < wallEnd);

  always_ff @(posedge clk) begin
    if (reset)                  rgb <= 6'h00;
    else if (!visibleQ)         rgb <= 6'h00;
    else if (inWall)            rgb <= sideQ ? WALL1 : WALL0;
    else if (vposExt < Horizon11) rgb <= SKY;
    else                        rgb <= FLOOR;
  end

endmodule

// File: tb/tb_trace_column_renderer.sv
// Self-checking bench: hand-written vector table plus randomized traffic
// against a bank/pixel reference model.
module tb_trace_column_renderer;

  localparam int SKY = 'h0B, FLOOR = 'h15, WALL0 = 'h30, WALL1 = 'h20;

  logic       clk;
  logic       reset;
  logic       frame_end;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       visible;
  logic [5:0] rgb;
  logic       front_bank;
  logic       front_valid;

  trace_column_renderer_if colBus ();

  trace_column_renderer dut (
    .clk         (clk),
    .reset       (reset),
    .colBus      (colBus.slave),
    .frame_end   (frame_end),
    .hpos        (hpos),
    .vpos        (vpos),
    .visible     (visible),
    .rgb         (rgb),
    .front_bank  (front_bank),
    .front_valid (front_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit st; int col; bit sd; int ht; bit fe;
    int hp; int vp; bit vis; int expRgb; int expFv;
  } vec_t;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: per-bank column arrays and display state.
  int mSide [2][640];
  int mHt   [2][640];
  int fb = 0, fv = 0, dirty = 0;
  int pendModel = 0, pendTable = -1;

  function automatic vec_t V(bit rst, bit st, int col, bit sd, int ht, bit fe,
                             int hp, int vp, bit vis, int er, int ef);
    vec_t v;
    v.rst = rst; v.st = st; v.col = col; v.sd = sd; v.ht = ht; v.fe = fe;
    v.hp = hp; v.vp = vp; v.vis = vis; v.expRgb = er; v.expFv = ef;
    return v;
  endfunction

  function automatic int modelPixel(int hp, int vp, bit vis);
    int h, s;
    if (!vis) return 0;
    h = 0; s = 0;
    if (fv != 0 && hp < 640) begin
      h = mHt[fb][hp];
      s = mSide[fb][hp];
    end
    if (h != 0 && vp >= 240 - h && vp < 240 + h) return (s != 0) ? WALL1 : WALL0;
    if (vp < 240) return SKY;
    return FLOOR;
  endfunction

  task automatic check(string name, int act, int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(vec_t v);
    int mexp;
    bit acc;
    reset         = v.rst;
    colBus.store  = v.st;
    colBus.column = 10'(v.col);
    colBus.side   = v.sd;
    colBus.height = 8'(v.ht);
    frame_end     = v.fe;
    hpos          = 10'(v.hp);
    vpos          = 10'(v.vp);
    visible       = v.vis;
    mexp = modelPixel(v.hp, v.vp, v.vis);
    if (v.rst) begin
      fb = 0; fv = 0; dirty = 0;
    end else begin
      acc = v.st && (v.col < 640);
      if (acc) begin
        mSide[1 - fb][v.col] = v.sd;
        mHt[1 - fb][v.col]   = (v.ht > 240) ? 240 : v.ht;
      end
      if (v.fe) begin
        fb = 1 - fb; fv = (dirty != 0 || acc) ? 1 : 0; dirty = 0;
      end else if (acc) begin
        dirty = 1;
      end
    end
    @(posedge clk);
    #1;
    if (v.rst) begin
      check("rgb_after_reset", int'(rgb), 0);
    end else begin
      check("rgb_model", int'(rgb), pendModel);
      if (pendTable >= 0) check("rgb_table", int'(rgb), pendTable);
    end
    check("front_bank", int'(front_bank), fb);
    check("front_valid", int'(front_valid), fv);
    if (v.expFv >= 0) check("front_valid_table", int'(front_valid), v.expFv);
    pendModel = v.rst ? 0 : mexp;
    pendTable = v.rst ? -1 : v.expRgb;
  endtask

  vec_t tblA[$];
  vec_t tblB[$];

  initial begin
    reset = 1'b1; frame_end = 1'b0; hpos = '0; vpos = '0; visible = 1'b0;
    colBus.store = 1'b0; colBus.column = '0; colBus.side = 1'b0; colBus.height = '0;

    // Post-reset: sky/floor only, black when not visible.
    tblA.push_back(V(1,0,0,0,0,0, 0,0,0, -1,0));
    tblA.push_back(V(1,0,0,0,0,0, 0,0,0, -1,0));
    tblA.push_back(V(0,0,0,0,0,0, 5,100,1, SKY,0));
    tblA.push_back(V(0,0,0,0,0,0, 5,239,1, SKY,0));
    tblA.push_back(V(0,0,0,0,0,0, 5,240,1, FLOOR,0));
    tblA.push_back(V(0,0,0,0,0,0, 5,479,1, FLOOR,0));
    tblA.push_back(V(0,0,0,0,0,0, 5,100,0, 0,0));
    tblA.push_back(V(0,0,0,0,0,0, 600,10,1, SKY,0));
    foreach (tblA[i]) step(tblA[i]);

    // Fill both banks with known random contents.
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < 640; c++)
        step(V(0,1,c,1'($urandom_range(0,1)),$urandom_range(0,255),0,
               $urandom_range(0,700),$urandom_range(0,524),1'($urandom_range(0,1)),-1,-1));
      step(V(0,0,0,0,0,1, 0,0,0, -1,1));
    end

    // Front bank 0, writing bank 1.
    tblB.push_back(V(0,1,5,0,10,0, 0,0,0, 0,1));
    tblB.push_back(V(0,0,0,0,0,1, 0,0,0, 0,1));
    tblB.push_back(V(0,0,0,0,0,0, 5,229,1, SKY,-1));
    tblB.push_back(V(0,0,0,0,0,0, 5,230,1, WALL0,-1));
    tblB.push_back(V(0,0,0,0,0,0, 5,249,1, WALL0,-1));
    tblB.push_back(V(0,0,0,0,0,0, 5,250,1, FLOOR,-1));
    // Height clamp, out-of-range column write and read.
    tblB.push_back(V(0,1,639,1,255,0, 0,0,0, 0,-1));
    tblB.push_back(V(0,1,640,0,100,0, 0,0,0, 0,-1));
    tblB.push_back(V(0,1,7,0,20,0, 0,0,0, 0,-1));
    tblB.push_back(V(0,0,0,0,0,0, 640,239,1, SKY,-1));
    tblB.push_back(V(0,0,0,0,0,0, 640,240,1, FLOOR,-1));
    tblB.push_back(V(0,0,0,0,0,1, 0,0,0, 0,1));
    tblB.push_back(V(0,0,0,0,0,0, 639,0,1, WALL1,-1));
    tblB.push_back(V(0,0,0,0,0,0, 639,479,1, WALL1,-1));
    tblB.push_back(V(0,0,0,0,0,0, 639,480,1, FLOOR,-1));
    tblB.push_back(V(0,0,0,0,0,0, 7,225,1, WALL0,-1));
    tblB.push_back(V(0,0,0,0,0,0, 7,219,1, SKY,-1));
    // Back-bank write to col 7 stays hidden until the swap.
    tblB.push_back(V(0,1,7,1,5,0, 0,0,0, 0,-1));
    tblB.push_back(V(0,0,0,0,0,0, 7,225,1, WALL0,-1));
    tblB.push_back(V(0,0,0,0,0,1, 7,225,1, WALL0,1));
    tblB.push_back(V(0,0,0,0,0,0, 7,225,1, SKY,-1));
    tblB.push_back(V(0,0,0,0,0,0, 7,236,1, WALL1,-1));
    tblB.push_back(V(0,0,0,0,0,0, 7,244,1, WALL1,-1));
    tblB.push_back(V(0,0,0,0,0,0, 7,245,1, FLOOR,-1));
    // Store coinciding with the swap.
    tblB.push_back(V(0,1,9,1,50,1, 0,0,0, 0,1));
    tblB.push_back(V(0,0,0,0,0,0, 9,200,1, WALL1,-1));
    tblB.push_back(V(0,0,0,0,0,0, 9,189,1, SKY,-1));
    tblB.push_back(V(0,0,0,0,0,0, 9,289,1, WALL1,-1));
    tblB.push_back(V(0,0,0,0,0,0, 9,290,1, FLOOR,-1));
    // Back-to-back swaps with no stores.
    tblB.push_back(V(0,0,0,0,0,1, 0,0,0, 0,0));
    tblB.push_back(V(0,0,0,0,0,1, 0,0,0, 0,0));
    tblB.push_back(V(0,0,0,0,0,0, 9,200,1, SKY,0));
    tblB.push_back(V(0,0,0,0,0,0, 9,300,1, FLOOR,0));
    // Reset while bank 1 is on screen.
    tblB.push_back(V(0,0,0,0,0,1, 0,0,0, 0,0));
    tblB.push_back(V(0,0,0,0,0,0, 9,300,1, FLOOR,0));
    tblB.push_back(V(1,0,0,0,0,0, 9,100,1, 0,0));
    tblB.push_back(V(0,0,0,0,0,0, 5,100,1, SKY,0));
    tblB.push_back(V(0,0,0,0,0,0, 5,100,0, 0,0));
    foreach (tblB[i]) step(tblB[i]);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      bit r, s, f;
      r = ($urandom_range(0,499) == 0);
      s = !r && ($urandom_range(0,1) == 1);
      f = !r && ($urandom_range(0,39) == 0);
      step(V(r, s, $urandom_range(0,700), 1'($urandom_range(0,1)), $urandom_range(0,255), f,
             $urandom_range(0,700), $urandom_range(0,524), 1'($urandom_range(0,3) != 0), -1, -1));
    end
    step(V(0,0,0,0,0,0, 0,0,0, -1,-1));
    step(V(0,0,0,0,0,0, 0,0,0, -1,-1));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/trace_column_renderer.md
# trace_column_renderer

Receiving end of the tracer's column-store interface. Holds per-column wall results (`side`, `height`) in a double-buffered column memory and renders them. The tracer fills the back bank during VBLANK; the front bank is read at pixel rate to produce each pixel's 6-bit colour for the VGA output stage. Sits between the tracer and the VGA sync/output logic.

## Interface
Parameters:
- `COLUMNS`, 640: number of column entries per bank.
- `HORIZON`, 240: screen row of the horizon (wall vertical centre).
- `MAX_HEIGHT`, 240: clamp for stored half-height.
- `SKY`, 6'h0B: sky colour.
- `FLOOR`, 6'h15: floor colour.
- `WALL0`, 6'h30: wall colour for side 0.
- `WALL1`, 6'h20: wall colour for side 1.

Ports:
- `clk` input 1: clock.
- `reset` input 1: reset; synchronous, active-high.
- `store` input 1: write strobe from the tracer.
- `column` input 10: column index to write.
- `side` input 1: wall side for the written column.
- `height` input 8: wall half-height for the written column.
- `frame_end` input 1: single-cycle pulse at end of VBLANK; swaps the banks.
- `hpos` input 10: pixel column being requested.
- `vpos` input 10: pixel row being requested.
- `visible` input 1: requested pixel is in the active area.
- `rgb` output 6: `{r[1:0],g[1:0],b[1:0]}`, registered.
- `front_bank` output 1: index of the bank currently being displayed.
- `front_valid` output 1: front bank holds a complete traced frame.

## Operation
- Two banks, each `COLUMNS` entries × 9 bits `{side,height}`. Write bank = `~front_bank`; read bank = `front_bank`.
- Write: on a cycle with `store`=1 and `column < COLUMNS`, write `{side, min(height, MAX_HEIGHT)}` to the write bank at `column`. If `column >= COLUMNS`, ignore the write. Writes are never blocked, so the tracer needs no handshake.
- `back_dirty` sets on any accepted write and clears on swap.
- Swap: on `frame_end`=1, toggle `front_bank`, set `front_valid <= back_dirty`, and clear `back_dirty`.
- Simultaneous `store` and `frame_end`: the write lands in the pre-swap write bank and counts toward the `back_dirty` value transferred.
- Bank contents are not cleared by reset.
- While `front_valid`=0, read height is forced to 0, so only sky and floor are shown.
- Pixel pipeline, stage 1: register `hpos`, `vpos` and `visible`. Issue a read-bank read at `hpos`; for `hpos >= COLUMNS`, force height 0.
- Pixel pipeline, stage 2: with read data `h`, `s`, compute `rgb` as follows:
  - `visible`=0 → 6'h00;
  - else `h != 0` and `HORIZON-h <= vpos < HORIZON+h` → `s ? WALL1 : WALL0`;
  - else `vpos < HORIZON` → `SKY`;
  - else → `FLOOR`.
- Arithmetic: compute the row compares in 11-bit unsigned, so `HORIZON-h` never wraps for `h <= MAX_HEIGHT`. `h=240` spans rows 0..479 inclusive.
- Reset values: `rgb`=0, `front_bank`=0, `front_valid`=0, `back_dirty`=0, pipeline registers cleared (`visible` stage = 0).

## Timing
- Write latency: 1 cycle. Data is stored at the clock edge where `store`=1.
- Read latency: `rgb` reflects the `hpos`/`vpos`/`visible` presented 2 cycles earlier. The sync generator supplies positions 2 clocks ahead.
- Swap takes effect at the `frame_end` edge. Pixel requests issued in the cycle after the swap read the new front bank. A request already in stage 2 completes using data read before the swap.
- One read and one write per cycle, on different banks. No read/write collision is possible.
- Reset mid-operation: the pipeline flushes to black within 1 cycle. The `front_valid`=0 forcing applies on the next request.
- Back-to-back `frame_end` pulses each toggle the bank. The second swap sets `front_valid`=0 unless stores arrived between the two pulses.

## Test plan
- Reset, then request pixels with `visible`=1 → `rgb`=`SKY` for `vpos`<240 and `FLOOR` for `vpos`>=240, with `front_valid`=0. With `visible`=0 → `rgb`=0.
- Store col 5 `{side 0, height 10}`, pulse `frame_end`, request `hpos`=5 at `vpos` 229, 230, 249, 250 → `SKY`, `WALL0`, `WALL0`, `FLOOR`, each 2 cycles after request.
- Store col 639 `{side 1, height 255}`, swap, request `vpos` 0 and 479 → `WALL1` for both (height clamped to 240). Store to col 640 → ignored, bank contents unchanged.
- During display of bank 0, write new data for col 7 to bank 1 → col 7 display unchanged until `frame_end`. After the swap → new value shown.
- `store` and `frame_end` in the same cycle, with no other stores → `front_valid`=1 after the swap, and that column shows the stored wall.
- Two `frame_end` pulses with no stores between them → `front_valid`=0 and sky/floor only. Assert `reset` mid-frame → `rgb`=0 on the next cycle and `front_bank`=0.
